prog_ram: RTL and testbench
===========================

Name: prog_ram

Overview:
Parametrised synchronous program/data RAM for the SAP-1 datapath. It is the successor to the fixed 16x8 memory. It adds:
- a clocked, registered read port
- optional clear-on-reset sequencing
- a byte-loader mode that fills memory from address 0 over a valid/ready handshake, standing in for the front-panel switch programming of the original machine.

The CPU side connects to the MAR/bus exactly as before. The loader side connects to a UART or switch debouncer.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width.
- CLEAR_ON_RESET, 1. When 1, reset triggers a zero-fill of every word. When 0, contents survive reset.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_we  in  1  CPU write enable; honoured only in RUN.
- cpu_adr  in  ADDR_W  CPU address (from MAR).
- cpu_din  in  DATA_W  CPU write data (from bus).
- cpu_dout  out  DATA_W  registered read data.
- prog_mode  in  1  level: 1 requests loader mode, 0 requests run mode.
- ld_valid  in  1  loader byte valid.
- ld_data  in  DATA_W  loader byte.
- ld_ready  out  1  loader may transfer; combinational, equal to (state==LOAD).
- ld_count  out  ADDR_W+1  bytes accepted since entering LOAD; saturates at DEPTH.
- busy  out  1  high in CLEAR; CPU must stall.

Behaviour:
- Reset (sampled on clk edge):
  - state <= CLEAR if CLEAR_ON_RESET, else RUN
  - clr_ptr <= 0, ld_ptr <= 0, ld_count <= 0, cpu_dout <= 0
  - busy = 1 if CLEAR_ON_RESET, else 0; ld_ready = 0
  - Reset overrides every other input in the same cycle.
- CLEAR:
  - Each cycle writes mem[clr_ptr] <= 0 and increments clr_ptr.
  - After the cycle that writes DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH cycles, so busy falls on the edge after the last write.
  - cpu_we, prog_mode and ld_valid are ignored. cpu_dout holds 0.
- RUN:
  - cpu_dout <= mem[cpu_adr] every cycle (1-cycle read latency).
  - If cpu_we=1: mem[cpu_adr] <= cpu_din.
  - Simultaneous read and write to the same address: read-first. cpu_dout shows the old word; the new word appears on the following read.
  - If prog_mode=1: go to LOAD, with ld_ptr <= 0 and ld_count <= 0. A cpu_we in that same cycle is still performed.
- LOAD:
  - ld_ready=1.
  - Transfer occurs when ld_valid && ld_ready. Then mem[ld_ptr] <= ld_data; ld_ptr <= ld_ptr+1 mod DEPTH; ld_count <= min(ld_count+1, DEPTH).
  - Wrap-around: byte DEPTH+1 overwrites address 0. ld_count stays at DEPTH.
  - cpu_we is ignored. The read port stays live: cpu_dout <= mem[cpu_adr], read-first against a loader write to the same address.
  - If prog_mode=0: a transfer in that same cycle is still accepted, then go to RUN. ld_count holds its final value until the next entry to LOAD.
- Reset mid-LOAD or mid-CLEAR: restart per the reset rules.
  - If CLEAR_ON_RESET=0, partially loaded contents are retained.
- No X on outputs after reset. Memory contents are undefined before the first reset when CLEAR_ON_RESET=0.

Test Plan:
1. Reset with CLEAR_ON_RESET=1 (defaults) -> busy high for exactly 16 cycles. Afterwards, reads of addresses 0..15 return 0x00. A cpu_we of 0x55 to address 3 during CLEAR is not stored.
2. prog_mode=1, then load 0x09,0x1A,0x2B,0xE0,0xF0 followed by 0x0F,0x0E,0x01 at addresses 9..11 (padding zeros at 5..8), with ld_valid gaps inserted -> ld_count=12. After prog_mode=0, reading addresses 0..4 returns 0x09,0x1A,0x2B,0xE0,0xF0, each one cycle after the address is presented.
3. In RUN: write 0xAA to address 7 while reading address 7 -> cpu_dout=old value. Next cycle cpu_dout=0xAA.
4. Load 17 bytes 0x01..0x11 -> address 0 holds 0x11, address 1 holds 0x02, ld_count=16.
5. With CLEAR_ON_RESET=0: load 3 bytes, assert reset, reread -> bytes retained, ld_count=0, state RUN, busy=0.
6. Transfer in the same cycle prog_mode drops -> byte written. The next ld_valid is not accepted (ld_ready=0).

Source files
------------

// File: rtl/prog_ram_if.sv
// CPU and loader signal bundle for prog_ram. The master side drives the
// requests and the slave (the RAM) drives read data and loader status.
interface prog_ram_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              prog_mode;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_count;
  logic              busy;

  modport master (
    output cpu_we, cpu_adr, cpu_din, prog_mode, ld_valid, ld_data,
    input  cpu_dout, ld_ready, ld_count, busy
  );

  modport slave (
    input  cpu_we, cpu_adr, cpu_din, prog_mode, ld_valid, ld_data,
    output cpu_dout, ld_ready, ld_count, busy
  );
endinterface

// File: rtl/prog_ram.sv
// SAP-1 program/data RAM: registered read port, optional zero-fill after reset,
// and a byte loader that fills memory from address 0 over valid/ready.
module prog_ram #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic     clk,
  input logic     reset,
  prog_ram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] ld_ptr;
  logic [ADDR_W:0]   ld_count;
  logic [DATA_W-1:0] dout;
  logic              busy;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // Single write port shared by the clear sequencer, the CPU and the loader.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (!reset) begin
      case (state)
        CLEAR: begin
          mem_we = 1'b1;
          mem_wa = clr_ptr;
        end
        RUN: begin
          mem_we = bus.cpu_we;
          mem_wa = bus.cpu_adr;
          mem_wd = bus.cpu_din;
        end
        LOAD: begin
          mem_we = bus.ld_valid;
          mem_wa = ld_ptr;
          mem_wd = bus.ld_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      busy     <= (CLEAR_ON_RESET != 0);
      clr_ptr  <= '0;
      ld_ptr   <= '0;
      ld_count <= '0;
      dout     <= '0;
    end else begin
      case (state)
        CLEAR: begin
          dout    <= '0;
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == '1) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          dout <= mem[bus.cpu_adr];
          if (bus.prog_mode) begin
            state    <= LOAD;
            ld_ptr   <= '0;
            ld_count <= '0;
          end
        end
        LOAD: begin
          dout <= mem[bus.cpu_adr];
          if (bus.ld_valid) begin
            ld_ptr <= ld_ptr + 1'b1;
            // Count saturates at DEPTH even though the pointer wraps.
            if (ld_count != (ADDR_W+1)'(DEPTH))
              ld_count <= ld_count + 1'b1;
          end
          if (!bus.prog_mode)
            state <= RUN;
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_dout = dout;
  assign bus.ld_count = ld_count;
  assign bus.busy     = busy;
  assign bus.ld_ready = (state == LOAD);
endmodule

// File: tb/tb_prog_ram.sv
// Randomized and directed check of prog_ram (clear-on-reset and retain variants
// side by side, same stimulus) against an array-based model of the memory rules.
module tb_prog_ram;
  localparam int MC = 0, MR = 1, ML = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0, pm = 1'b0, lv = 1'b0;
  logic [3:0] adr = '0;
  logic [7:0] din = '0, ld = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_ram_if #(.ADDR_W(4), .DATA_W(8)) b1 ();
  prog_ram_if #(.ADDR_W(4), .DATA_W(8)) b0 ();

  assign b1.cpu_we = we;  assign b1.cpu_adr = adr; assign b1.cpu_din = din;
  assign b1.prog_mode = pm; assign b1.ld_valid = lv; assign b1.ld_data = ld;
  assign b0.cpu_we = we;  assign b0.cpu_adr = adr; assign b0.cpu_din = din;
  assign b0.prog_mode = pm; assign b0.ld_valid = lv; assign b0.ld_data = ld;

  prog_ram #(.ADDR_W(4), .DATA_W(8), .CLEAR_ON_RESET(1)) dut1 (.clk(clk), .reset(rst), .bus(b1));
  prog_ram #(.ADDR_W(4), .DATA_W(8), .CLEAR_ON_RESET(0)) dut0 (.clk(clk), .reset(rst), .bus(b0));

  // Model state, index 1 = clear-on-reset instance, index 0 = retain instance.
  logic [7:0] m_mem [2][16];
  bit         m_kn  [2][16];
  int         m_mode[2], m_clr[2], m_ptr[2], m_cnt[2];
  logic [7:0] m_dout[2];
  bit         m_dv[2], m_init[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_init[i] = 0; m_dv[i] = 0; m_mode[i] = MR; m_cnt[i] = 0;
      m_clr[i] = 0; m_ptr[i] = 0; m_dout[i] = '0;
      for (int a = 0; a < 16; a++) begin m_kn[i][a] = 0; m_mem[i][a] = '0; end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    if (rst) begin
      m_init[i] = 1;
      m_mode[i] = (i == 1) ? MC : MR;
      m_clr[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
      m_dout[i] = '0; m_dv[i] = 1;
    end else if (m_mode[i] == MC) begin
      m_mem[i][m_clr[i]] = '0; m_kn[i][m_clr[i]] = 1;
      m_dout[i] = '0; m_dv[i] = 1;
      if (m_clr[i] == 15) m_mode[i] = MR;
      m_clr[i] = (m_clr[i] + 1) % 16;
    end else begin
      m_dout[i] = m_mem[i][adr]; m_dv[i] = m_kn[i][adr];
      if (m_mode[i] == MR) begin
        if (we) begin m_mem[i][adr] = din; m_kn[i][adr] = 1; end
        if (pm) begin m_mode[i] = ML; m_ptr[i] = 0; m_cnt[i] = 0; end
      end else begin
        if (lv) begin
          m_mem[i][m_ptr[i]] = ld; m_kn[i][m_ptr[i]] = 1;
          m_ptr[i] = (m_ptr[i] + 1) % 16;
          m_cnt[i] = (m_cnt[i] < 16) ? m_cnt[i] + 1 : 16;
        end
        if (!pm) m_mode[i] = MR;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  always @(negedge clk) begin
    if (m_init[1]) begin
      chk("busy1", b1.busy, m_mode[1] == MC);
      chk("ready1", b1.ld_ready, m_mode[1] == ML);
      chk("count1", b1.ld_count, m_cnt[1]);
      if (m_dv[1]) chk("dout1", b1.cpu_dout, m_dout[1]);
    end
    if (m_init[0]) begin
      chk("busy0", b0.busy, m_mode[0] == MC);
      chk("ready0", b0.ld_ready, m_mode[0] == ML);
      chk("count0", b0.ld_count, m_cnt[0]);
      if (m_dv[0]) chk("dout0", b0.cpu_dout, m_dout[0]);
    end
  end

  logic [7:0] prog [12];
  int n;

  initial begin
    prog = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0E, 8'h01};

    // Reset, then count CLEAR cycles while the CPU tries to write 0x55 to address 3.
    rst = 1'b1; cyc();
    chk("busy_after_reset", b1.busy, 1'b1);
    rst = 1'b0; we = 1'b1; adr = 4'd3; din = 8'h55;
    n = 0;
    while (b1.busy && n < 40) begin cyc(); n++; end
    chk("clear_cycles", n, 16);
    we = 1'b0;
    for (int a = 0; a < 16; a++) begin
      adr = 4'(a); cyc();
      chk("cleared_word", b1.cpu_dout, 8'h00);
    end

    // Loader fill with random valid gaps.
    pm = 1'b1; cyc();
    chk("ready_in_load", b1.ld_ready, 1'b1);
    for (int k = 0; k < 12; k++) begin
      lv = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
      lv = 1'b1; ld = prog[k]; cyc();
    end
    lv = 1'b0;
    chk("load_count12", b1.ld_count, 12);
    pm = 1'b0; cyc();
    for (int a = 0; a < 12; a++) begin
      adr = 4'(a); cyc();
      chk("loaded_word", b1.cpu_dout, prog[a]);
    end

    // Read-first on a same-address CPU write.
    adr = 4'd7; we = 1'b1; din = 8'hAA; cyc();
    chk("rdfirst_old", b1.cpu_dout, 8'h00);
    we = 1'b0; cyc();
    chk("rdfirst_new", b1.cpu_dout, 8'hAA);

    // 17-byte load wraps onto address 0; count saturates.
    pm = 1'b1; cyc();
    for (int k = 1; k <= 17; k++) begin lv = 1'b1; ld = 8'(k); cyc(); end
    lv = 1'b0; pm = 1'b0; cyc();
    chk("wrap_count", b1.ld_count, 16);
    adr = 4'd0; cyc(); chk("wrap_addr0", b1.cpu_dout, 8'h11);
    adr = 4'd1; cyc(); chk("wrap_addr1", b1.cpu_dout, 8'h02);

    // Transfer in the cycle prog_mode drops is taken; the next one is not.
    pm = 1'b1; cyc();
    lv = 1'b1; ld = 8'h77; pm = 1'b0; cyc();
    chk("exit_count", b1.ld_count, 1);
    chk("exit_ready", b1.ld_ready, 1'b0);
    ld = 8'h88; cyc();
    chk("exit_count_hold", b1.ld_count, 1);
    lv = 1'b0; adr = 4'd0; cyc();
    chk("exit_byte", b1.cpu_dout, 8'h77);

    // Partial load, reset: the retain instance keeps its bytes.
    pm = 1'b1; cyc();
    lv = 1'b1; ld = 8'hA1; cyc(); ld = 8'hB2; cyc(); ld = 8'hC3; cyc();
    lv = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0; pm = 1'b0;
    chk("retain_busy", b0.busy, 1'b0);
    chk("retain_count", b0.ld_count, 0);
    chk("retain_ready", b0.ld_ready, 1'b0);
    adr = 4'd0; cyc(); chk("retain_0", b0.cpu_dout, 8'hA1);
    adr = 4'd1; cyc(); chk("retain_1", b0.cpu_dout, 8'hB2);
    adr = 4'd2; cyc(); chk("retain_2", b0.cpu_dout, 8'hC3);
    repeat (16) cyc();

    // Random traffic, checked cycle by cycle against the model.
    for (int t = 0; t < 1500; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      we  = $urandom_range(0, 1) != 0;
      adr = 4'($urandom_range(0, 15));
      din = 8'($urandom);
      if ($urandom_range(0, 9) == 0) pm = ~pm;
      lv  = $urandom_range(0, 2) != 0;
      ld  = 8'($urandom);
      cyc();
    end
    rst = 1'b0; we = 1'b0; lv = 1'b0; pm = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
